membrane_rmw_ctrl: RTL and testbench

MEMBRANE_RMW_CTRL -- requirements
Module: membrane_rmw_ctrl

---
 rtl/membrane_rmw_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_membrane_rmw_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/membrane_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : membrane_rmw_ctrl
//  Brief    : Read-modify-write controller for a neuron membrane-potential
//             memory.
//             Each spike event adds a signed weight to one neuron's potential.
//             The sum saturates to the data range. If the sum reaches THRESH,
//             the neuron fires and its potential is reset to 0.
//             A bulk clear zeroes the whole memory through port B.
//             Define RMW_FWD_EN to forward the last write into the next
//             read-modify-write. Without it, back-to-back hits on the same
//             address stall for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module membrane_rmw_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int THRESH     = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_weight,
    input  logic                  clear_start,
    output logic                  busy,
    output logic                  spike_valid,
    output logic [ADDR_WIDTH-1:0] spike_addr,
    output logic                  ram_ena,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    input  logic [DATA_WIDTH-1:0] ram_doa,
    output logic                  ram_enb,
    output logic                  ram_web,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic [DATA_WIDTH-1:0] ram_dib
);

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_drain = 2'd1;
    localparam logic [1:0] c_st_clear = 2'd2;

    localparam logic [ADDR_WIDTH-1:0]        c_addr_last = '1;
    localparam logic signed [DATA_WIDTH-1:0] c_thresh    = THRESH[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0]        c_sat_max   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]        c_sat_min   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;

    logic                  r_s1_valid;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [DATA_WIDTH-1:0] r_s1_weight;

    logic                  r_lw_valid;
    logic [ADDR_WIDTH-1:0] r_lw_addr;
    logic [DATA_WIDTH-1:0] r_lw_data;

    logic                  w_stall;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_pot;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_sat;
    logic                  w_fire;
    logic                  w_rmw_wr;
    logic                  w_clr_wr;

`ifdef RMW_FWD_EN
    // Forwarding covers the read-after-write hazard, so requests never stall
    assign w_stall = 1'b0;
    // The RAM read was launched before the previous write landed; patch it
    assign w_pot   = (r_lw_valid && (r_lw_addr == r_s1_addr)) ? r_lw_data : ram_doa;
`else
    // A hit on the in-flight address would read stale data; hold it one cycle
    assign w_stall = r_s1_valid && (in_addr == r_s1_addr);
    assign w_pot   = ram_doa;
    // The last-write register is only consumed by the forwarding path
    logic w_lw_unused;
    assign w_lw_unused = ^{r_lw_valid, r_lw_addr, r_lw_data};
`endif

    assign in_ready  = (r_state == c_st_run) && !w_stall;
    assign w_accept  = in_valid && in_ready && !reset;
    assign ram_ena   = w_accept;
    assign ram_addra = in_addr;
    assign busy      = (r_state != c_st_run);

    // Sign-extended add, one guard bit to detect overflow
    assign w_sum = {w_pot[DATA_WIDTH-1], w_pot} + {r_s1_weight[DATA_WIDTH-1], r_s1_weight};

    // Clamp the sum to the signed data range when the guard bit disagrees
    always_comb begin
        w_sat = w_sum[DATA_WIDTH-1:0];
        if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1]) begin
            w_sat = w_sum[DATA_WIDTH] ? c_sat_min : c_sat_max;
        end
    end

    assign w_fire   = ($signed(w_sat) >= c_thresh);
    // Writes are gated by reset so an aborted operation leaves memory untouched
    assign w_rmw_wr = r_s1_valid && !reset;
    assign w_clr_wr = (r_state == c_st_clear) && !reset;

    // Fire pulses only come out of normal operation, never during drain/clear
    assign spike_valid = w_rmw_wr && w_fire && (r_state == c_st_run);
    assign spike_addr  = r_s1_addr;

    // Port B write mux: the clear sweep, or the result of the read-modify-write
    always_comb begin
        ram_enb   = 1'b0;
        ram_web   = 1'b0;
        ram_addrb = '0;
        ram_dib   = '0;
        if (w_clr_wr) begin
            ram_enb   = 1'b1;
            ram_web   = 1'b1;
            ram_addrb = r_cnt;
            ram_dib   = '0;
        end else if (w_rmw_wr) begin
            ram_enb   = 1'b1;
            ram_web   = 1'b1;
            ram_addrb = r_s1_addr;
            ram_dib   = w_fire ? '0 : w_sat;
        end
    end

    // Control FSM: RUN -> DRAIN (one cycle for the in-flight write) -> CLEAR sweep
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_run;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (clear_start) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    r_state <= c_st_clear;
                end
                c_st_clear: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_addr_last) begin
                        r_state <= c_st_run;
                    end
                end
                default: begin
                    r_state <= c_st_run;
                end
            endcase
        end
    end

    // Stage 1 holds the accepted request while port A returns its data
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_weight <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_addr   <= in_addr;
                r_s1_weight <= in_weight;
            end
        end
    end

    // Last-write register mirrors every port B write of the previous cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lw_valid <= 1'b0;
            r_lw_addr  <= '0;
            r_lw_data  <= '0;
        end else begin
            r_lw_valid <= ram_enb && ram_web;
            r_lw_addr  <= ram_addrb;
            r_lw_data  <= ram_dib;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_membrane_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_membrane_rmw_ctrl
//  Brief    : Directed self-checking bench for membrane_rmw_ctrl with a
//             behavioural dual-port RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_membrane_rmw_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

`ifdef RMW_FWD_EN
    localparam int c_exp_stalls = 0;
`else
    localparam int c_exp_stalls = 1;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_weight;
    logic          clear_start;
    logic          busy;
    logic          spike_valid;
    logic [AW-1:0] spike_addr;
    logic          ram_ena;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_doa;
    logic          ram_enb;
    logic          ram_web;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dib;

    logic [DW-1:0] mem [DEPTH];
    logic          poke;
    logic [AW-1:0] poke_addr;
    logic [DW-1:0] poke_data;
    logic          fill;
    logic [DW-1:0] fill_val;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    membrane_rmw_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .THRESH     (256)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_weight   (in_weight),
        .clear_start (clear_start),
        .busy        (busy),
        .spike_valid (spike_valid),
        .spike_addr  (spike_addr),
        .ram_ena     (ram_ena),
        .ram_addra   (ram_addra),
        .ram_doa     (ram_doa),
        .ram_enb     (ram_enb),
        .ram_web     (ram_web),
        .ram_addrb   (ram_addrb),
        .ram_dib     (ram_dib)
    );

    // Dual-port RAM: registered read on A, write on B, plus bench preload paths
    always @(posedge clock) begin
        if (ram_ena) ram_doa <= mem[ram_addra];
        if (ram_enb && ram_web) mem[ram_addrb] <= ram_dib;
        if (poke) mem[poke_addr] <= poke_data;
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= fill_val;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic poke_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc();
        poke = 1'b1; poke_addr = a; poke_data = d;
        cyc();
        poke = 1'b0;
    endtask

    task automatic fill_mem(input logic [DW-1:0] v);
        cyc();
        fill = 1'b1; fill_val = v;
        cyc();
        fill = 1'b0;
    endtask

    initial begin
        int acc, stalls, nwr, spikes, busy_cnt, clr_wr, bad, nz, found, post_wr;
        logic [DW-1:0] wr0, wr1;
        logic [31:0]   first_addr;

        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_weight = '0;
        clear_start = 1'b0; poke = 1'b0; poke_addr = '0; poke_data = '0;
        fill = 1'b0; fill_val = '0;
        repeat (3) cyc();
        fill_mem(16'h1111);

        // ---------------- reset state
        cyc(); reset = 1'b0;
        mid();
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_spike_addr", spike_addr, 0);
        check("rst_ram_ena", ram_ena, 0);
        check("rst_ram_enb", ram_enb, 0);
        check("rst_ram_web", ram_web, 0);

        // ---------------- back-to-back to addr 5, weight 100
        poke_word(10'd5, 16'd0);
        acc = 0; stalls = 0; nwr = 0; spikes = 0; wr0 = '1; wr1 = '1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            in_valid = (acc < 2); in_addr = 10'd5; in_weight = 16'd100;
            mid();
            if (ram_enb && ram_web) begin
                if (nwr == 0) wr0 = ram_dib;
                else if (nwr == 1) wr1 = ram_dib;
                nwr++;
            end
            if (spike_valid) spikes++;
            if (in_valid) begin
                if (in_ready) acc++;
                else stalls++;
            end
        end
        in_valid = 1'b0;
        check("b2b_accepts", acc, 2);
        check("b2b_write_count", nwr, 2);
        check("b2b_write0", wr0, 16'd100);
        check("b2b_write1", wr1, 16'd200);
        check("b2b_stalls", stalls, c_exp_stalls);
        check("b2b_spikes", spikes, 0);
        check("b2b_mem5", mem[5], 16'd200);

        // ---------------- fire: 200 + 60
        poke_word(10'd7, 16'd200);
        cyc(); in_valid = 1'b1; in_addr = 10'd7; in_weight = 16'd60;
        mid();
        check("fire_in_ready", in_ready, 1);
        check("fire_ram_ena", ram_ena, 1);
        check("fire_ram_addra", ram_addra, 7);
        cyc(); in_valid = 1'b0;
        mid();
        check("fire_spike_valid", spike_valid, 1);
        check("fire_spike_addr", spike_addr, 7);
        check("fire_ram_enb", ram_enb, 1);
        check("fire_ram_addrb", ram_addrb, 7);
        check("fire_ram_dib", ram_dib, 0);
        cyc();
        mid();
        check("fire_pulse_end", spike_valid, 0);
        check("fire_mem7", mem[7], 0);

        // ---------------- saturation both ways
        poke_word(10'd3, 16'h7FBC);   // 32700
        poke_word(10'd4, 16'h8044);   // -32700
        cyc(); in_valid = 1'b1; in_addr = 10'd3; in_weight = 16'h01F4;   // +500
        mid();
        cyc(); in_addr = 10'd4; in_weight = 16'hFE0C;                    // -500
        mid();
        check("satp_spike_valid", spike_valid, 1);
        check("satp_spike_addr", spike_addr, 3);
        check("satp_ram_dib", ram_dib, 0);
        cyc(); in_valid = 1'b0;
        mid();
        check("satn_spike_valid", spike_valid, 0);
        check("satn_ram_addrb", ram_addrb, 4);
        check("satn_ram_dib", ram_dib, 16'h8000);
        cyc();
        mid();
        check("satn_mem4", mem[4], 16'h8000);
        check("satp_mem3", mem[3], 0);

        // ---------------- threshold boundary: 256 fires, 255 does not
        poke_word(10'd9, 16'd200);
        poke_word(10'd10, 16'd200);
        cyc(); in_valid = 1'b1; in_addr = 10'd9; in_weight = 16'd56;
        mid();
        cyc(); in_addr = 10'd10; in_weight = 16'd55;
        mid();
        check("thr256_spike", spike_valid, 1);
        check("thr256_addr", spike_addr, 9);
        cyc(); in_valid = 1'b0;
        mid();
        check("thr255_spike", spike_valid, 0);
        check("thr255_dib", ram_dib, 16'd255);

        // ---------------- clear with a request in flight
        poke_word(10'd20, 16'd10);
        cyc(); in_valid = 1'b1; in_addr = 10'd20; in_weight = 16'd5; clear_start = 1'b1;
        mid();
        check("clr_accept_ready", in_ready, 1);
        check("clr_accept_busy", busy, 0);
        cyc(); in_valid = 1'b0; clear_start = 1'b0;
        mid();
        check("drain_busy", busy, 1);
        check("drain_in_ready", in_ready, 0);
        check("drain_ram_enb", ram_enb, 1);
        check("drain_ram_addrb", ram_addrb, 20);
        check("drain_ram_dib", ram_dib, 16'd15);
        busy_cnt = 1; clr_wr = 0; bad = 0;
        for (int c = 0; c < 1100 && busy; c++) begin
            cyc();
            clear_start = (c == 100);
            mid();
            if (busy) begin
                busy_cnt++;
                if (in_ready || spike_valid) bad++;
                if (ram_enb && ram_web && ram_dib == '0) clr_wr++;
            end
        end
        clear_start = 1'b0;
        check("clr_busy_cycles", busy_cnt, 1025);
        check("clr_write_count", clr_wr, 1024);
        check("clr_ready_or_spike", bad, 0);
        check("clr_done_busy", busy, 0);
        check("clr_done_ready", in_ready, 1);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nz++;
        check("clr_nonzero_words", nz, 0);

        // ---------------- reset aborts clear at counter 500
        fill_mem(16'h2222);
        cyc(); clear_start = 1'b1;
        mid();
        cyc(); clear_start = 1'b0;
        mid();
        found = 0; first_addr = 32'hFFFF_FFFF;
        for (int c = 0; c < 600 && found == 0; c++) begin
            cyc();
            mid();
            if (ram_enb && first_addr == 32'hFFFF_FFFF) first_addr = 32'(ram_addrb);
            if (ram_enb && ram_addrb == 10'd499) found = 1;
        end
        check("abort_reached_499", found, 1);
        check("abort_first_clear_addr", first_addr, 0);
        cyc(); reset = 1'b1;
        mid();
        check("abort_no_write_500", ram_enb, 0);
        cyc(); reset = 1'b0;
        mid();
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        post_wr = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            mid();
            if (ram_enb) post_wr++;
        end
        check("abort_post_writes", post_wr, 0);
        check("abort_mem0", mem[0], 0);
        check("abort_mem499", mem[499], 0);
        check("abort_mem500", mem[500], 16'h2222);
        check("abort_mem1023", mem[1023], 16'h2222);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
